gtech_aoi3_rr_arbiter: RTL and testbench

//  Round-robin arbiter that shares one 3-way AND-OR-INVERT bus mux among three requesters.

---
 rtl/gtech_aoi3_rr_arbiter_if.sv | 62 ++++++
 rtl/gtech_aoi3_rr_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_gtech_aoi3_rr_arbiter.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/gtech_aoi3_rr_arbiter_if.sv
//------------------------------------------------------------------------------
// Module   : gtech_aoi3_rr_arbiter_if
// Purpose  : Bus bundle between three masters and the round-robin AOI222
//            bus-mux arbiter.
// Ports    : REQ[2:0]      - level request per master
//            D0, D1, D2    - data from masters 0..2 (W bits each)
//            LOCK          - hold current grant (only with GTECH_AOI3_ARB_LOCK_EN)
//            GNT[2:0]      - registered one-hot grant, 000 = idle
//            BUSY          - registered |GNT
//            SWITCH        - registered one-cycle pulse on each new grant
//            Z             - inverted, AND-OR muxed bus (W bits)
// Modports : master (drives requests/data), slave (the arbiter)
// Config   : GTECH_AOI3_ARB_LOCK_EN adds the LOCK signal.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface gtech_aoi3_rr_arbiter_if #(
  parameter int W = 8
);
  logic [2:0]   REQ;
  logic [W-1:0] D0;
  logic [W-1:0] D1;
  logic [W-1:0] D2;
`ifdef GTECH_AOI3_ARB_LOCK_EN
  logic         LOCK;
`endif
  logic [2:0]   GNT;
  logic         BUSY;
  logic         SWITCH;
  logic [W-1:0] Z;

  modport master (
    output REQ,
    output D0,
    output D1,
    output D2,
`ifdef GTECH_AOI3_ARB_LOCK_EN
    output LOCK,
`endif
    input  GNT,
    input  BUSY,
    input  SWITCH,
    input  Z
  );

  modport slave (
    input  REQ,
    input  D0,
    input  D1,
    input  D2,
`ifdef GTECH_AOI3_ARB_LOCK_EN
    input  LOCK,
`endif
    output GNT,
    output BUSY,
    output SWITCH,
    output Z
  );
endinterface

`default_nettype wire

// File: rtl/gtech_aoi3_rr_arbiter.sv
//------------------------------------------------------------------------------
// Module   : gtech_aoi3_rr_arbiter
// Purpose  : Round-robin arbiter sequencing the select pairs of a shared
//            3-way AND-OR-INVERT (AOI222) bus mux. A registered one-hot grant
//            guarantees the inverted bus Z is driven by at most one source.
// Ports    : CP   - clock, rising edge
//            CD   - asynchronous active-low clear
//            bus  - gtech_aoi3_rr_arbiter_if.slave (REQ, D0..D2, [LOCK],
//                   GNT, BUSY, SWITCH, Z)
// Params   : W        - data / Z width
//            MAX_HOLD - cycles an owner keeps the grant while others wait
//                       (0 = never preempt)
//            CNT_W    - hold counter width, 2**CNT_W > MAX_HOLD
// Config   : GTECH_AOI3_ARB_LOCK_EN - adds LOCK, which suppresses preemption
//            while asserted (release by dropping REQ still applies).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module gtech_aoi3_rr_arbiter #(
  parameter int W        = 8,
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  wire logic                CP,
  input  wire logic                CD,
  gtech_aoi3_rr_arbiter_if.slave   bus
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } state_t;

  // Counter saturates one below MAX_HOLD; with preemption disabled it
  // simply stays at zero.
  localparam logic [CNT_W-1:0] C_CNT_SAT    = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);
  localparam logic             C_PREEMPT_EN = (MAX_HOLD != 0);

  state_t           state_q,  state_d;
  logic [1:0]       owner_q,  owner_d;   // owner index, meaningful in ST_OWNED
  logic [1:0]       ptr_q,    ptr_d;     // round-robin start point, 0..2
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [2:0]       gnt_q,    gnt_d;
  logic             busy_q,   busy_d;
  logic             switch_q, switch_d;

  logic             lock_active;
  logic [2:0]       owner_oh;
  logic [2:0]       others;
  logic [1:0]       idle_pick;
  logic [1:0]       other_pick;
  logic             owner_release;
  logic             owner_preempt;
  logic             new_grant;
  logic [1:0]       new_owner;

  // Modulo-3 increment; the unreachable code 3 folds back to 0.
  function automatic logic [1:0] f_inc3(input logic [1:0] v);
    logic [1:0] r;
    case (v)
      2'd0:    r = 2'd1;
      2'd1:    r = 2'd2;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

  // Index of the first set bit of req scanning start, start+1, start+2
  // (mod 3). Result is only meaningful when req != 0.
  function automatic logic [1:0] f_pick(input logic [2:0] req, input logic [1:0] start);
    logic [2:0] rot;
    logic [1:0] off;
    logic [1:0] idx;
    // rot[k] = req[(start + k) mod 3]
    case (start)
      2'd1:    rot = {req[0], req[2], req[1]};
      2'd2:    rot = {req[1], req[0], req[2]};
      default: rot = req;
    endcase
    if (rot[0])      off = 2'd0;
    else if (rot[1]) off = 2'd1;
    else             off = 2'd2;
    idx = start;
    if (idx == 2'd3) idx = 2'd0;
    if (off == 2'd1)      idx = f_inc3(idx);
    else if (off == 2'd2) idx = f_inc3(f_inc3(idx));
    return idx;
  endfunction

  function automatic logic [2:0] f_onehot(input logic [1:0] idx);
    logic [2:0] r;
    case (idx)
      2'd0:    r = 3'b001;
      2'd1:    r = 3'b010;
      2'd2:    r = 3'b100;
      default: r = 3'b000;
    endcase
    return r;
  endfunction

`ifdef GTECH_AOI3_ARB_LOCK_EN
  assign lock_active = bus.LOCK;
`else
  assign lock_active = 1'b0;
`endif

  assign owner_oh   = f_onehot(owner_q);
  assign others     = bus.REQ & ~owner_oh;
  assign idle_pick  = f_pick(bus.REQ, ptr_q);
  assign other_pick = f_pick(others, f_inc3(owner_q));

  // Release and preempt lead to the same hand-over, so they are simply OR-ed
  // by the next-state logic below.
  assign owner_release = ~|(bus.REQ & owner_oh);
  assign owner_preempt = C_PREEMPT_EN && (cnt_q == C_CNT_SAT) && (|others) && !lock_active;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    new_grant = 1'b0;
    new_owner = owner_q;

    case (state_q)
      ST_IDLE: begin
        if (|bus.REQ) begin
          new_grant = 1'b1;
          new_owner = idle_pick;
        end
      end
      ST_OWNED: begin
        if (owner_release || owner_preempt) begin
          if (|others) begin
            // Direct hand-over: no idle cycle between owners.
            new_grant = 1'b1;
            new_owner = other_pick;
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end else if (cnt_q != C_CNT_SAT) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (new_grant) begin
      state_d = ST_OWNED;
      owner_d = new_owner;
      ptr_d   = f_inc3(new_owner);
      cnt_d   = '0;
    end

    gnt_d    = (state_d == ST_OWNED) ? f_onehot(owner_d) : 3'b000;
    busy_d   = (state_d == ST_OWNED);
    switch_d = new_grant;
  end

  always_ff @(posedge CP or negedge CD) begin
    if (!CD) begin
      state_q  <= ST_IDLE;
      owner_q  <= 2'd0;
      ptr_q    <= 2'd0;
      cnt_q    <= '0;
      gnt_q    <= 3'b000;
      busy_q   <= 1'b0;
      switch_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      busy_q   <= busy_d;
      switch_q <= switch_d;
    end
  end

  assign bus.GNT    = gnt_q;
  assign bus.BUSY   = busy_q;
  assign bus.SWITCH = switch_q;

  // AOI222: an idle (or cleared) grant leaves Z all ones.
  assign bus.Z = ~(({W{gnt_q[0]}} & bus.D0) |
                   ({W{gnt_q[1]}} & bus.D1) |
                   ({W{gnt_q[2]}} & bus.D2));

endmodule

`default_nettype wire

// File: tb/tb_gtech_aoi3_rr_arbiter.sv
`default_nettype none

module tb_gtech_aoi3_rr_arbiter;

  localparam int W  = 8;
  localparam int MH = 4;

  typedef struct {
    logic [2:0]   gnt;
    logic         busy;
    logic         sw;
    logic [W-1:0] z;
  } exp_t;

  logic clk;
  logic cd;

  gtech_aoi3_rr_arbiter_if #(.W(W)) bus ();

  gtech_aoi3_rr_arbiter #(
    .W        (W),
    .MAX_HOLD (MH),
    .CNT_W    (4)
  ) u_dut (
    .CP  (clk),
    .CD  (cd),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];

  // Reference model: owner index (-1 = none), round-robin start, and the
  // number of edges the current owner has held the grant (grant edge = 1).
  int m_owner  = -1;
  int m_ptr    = 0;
  int m_tenure = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_owner  = -1;
    m_ptr    = 0;
    m_tenure = 0;
  endtask

  // Advance the model by one clock edge and return the expected outputs.
  task automatic model_step(input logic [2:0] req, input bit lck,
                            input logic [W-1:0] d0, input logic [W-1:0] d1,
                            input logic [W-1:0] d2, output exp_t e);
    int  nxt;
    int  cand;
    bit  rel;
    bit  pre;
    nxt = -1;
    if (m_owner < 0) begin
      for (int k = 0; k < 3; k++)
        if (nxt < 0 && req[(m_ptr + k) % 3]) nxt = (m_ptr + k) % 3;
    end else begin
      cand = -1;
      for (int k = 1; k < 3; k++)
        if (cand < 0 && req[(m_owner + k) % 3]) cand = (m_owner + k) % 3;
      rel = !req[m_owner];
      pre = (MH != 0) && (m_tenure >= MH) && (cand >= 0) && !lck;
      if (rel || pre) begin
        if (cand >= 0) nxt = cand;
        else           m_owner = -1;
      end else begin
        m_tenure++;
      end
    end
    if (nxt >= 0) begin
      m_owner  = nxt;
      m_ptr    = (nxt + 1) % 3;
      m_tenure = 1;
    end
    e.gnt  = (m_owner < 0) ? 3'b000 : 3'(1 << m_owner);
    e.busy = (m_owner >= 0);
    e.sw   = (nxt >= 0);
    case (m_owner)
      0:       e.z = ~d0;
      1:       e.z = ~d1;
      2:       e.z = ~d2;
      default: e.z = '1;
    endcase
  endtask

  // Called at a falling edge: drive inputs for the coming rising edge,
  // push the expected result, and move on to the next falling edge.
  task automatic cycle(input logic [2:0] req, input bit lck, input bit fix_d0, input logic [W-1:0] d0v);
    exp_t e;
    bus.REQ = req;
    bus.D0  = fix_d0 ? d0v : W'($urandom);
    bus.D1  = W'($urandom);
    bus.D2  = W'($urandom);
`ifdef GTECH_AOI3_ARB_LOCK_EN
    bus.LOCK = lck;
`endif
    model_step(req, lck, bus.D0, bus.D1, bus.D2, e);
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gnt"},    32'(bus.GNT),    32'h0);
    check({tag, "_busy"},   32'(bus.BUSY),   32'h0);
    check({tag, "_switch"}, 32'(bus.SWITCH), 32'h0);
    check({tag, "_z"},      32'(bus.Z),      32'hFF);
  endtask

  // Asynchronous clear in the middle of a cycle; called at a falling edge.
  task automatic mid_reset();
    @(posedge clk);
    #3;
    cd = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    cd = 1'b1;
    model_reset();
  endtask

  // Monitor: compare every registered output update against the scoreboard.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("gnt",    32'(bus.GNT),    32'(e.gnt));
      check("busy",   32'(bus.BUSY),   32'(e.busy));
      check("switch", 32'(bus.SWITCH), 32'(e.sw));
      check("z",      32'(bus.Z),      32'(e.z));
    end
  end

  initial begin
    logic [2:0] r;
    bit         l;
    cd      = 1'b0;
    bus.REQ = 3'b111;
    bus.D0  = 8'h12;
    bus.D1  = 8'h34;
    bus.D2  = 8'h56;
`ifdef GTECH_AOI3_ARB_LOCK_EN
    bus.LOCK = 1'b0;
`endif
    model_reset();
    @(negedge clk);
    check_reset_outputs("reset");

    // Release clear with all requesting: master 0 wins first.
    cd = 1'b1;
    cycle(3'b111, 1'b0, 1'b0, '0);
    cycle(3'b000, 1'b0, 1'b0, '0);
    cycle(3'b000, 1'b0, 1'b0, '0);

    // Fresh start, REQ=101 with D0=A5 -> Z=5A; then owner 0 drops -> 100.
    mid_reset();
    cycle(3'b101, 1'b0, 1'b1, 8'hA5);
    cycle(3'b101, 1'b0, 1'b1, 8'hA5);
    cycle(3'b100, 1'b0, 1'b0, '0);
    cycle(3'b100, 1'b0, 1'b0, '0);
    cycle(3'b000, 1'b0, 1'b0, '0);

    // Two contenders held: alternate every MAX_HOLD cycles.
    for (int i = 0; i < 4 * MH + 2; i++) cycle(3'b011, 1'b0, 1'b0, '0);
    cycle(3'b000, 1'b0, 1'b0, '0);

    // Lone requester keeps the grant, single SWITCH, then drops.
    for (int i = 0; i < 20; i++) cycle(3'b010, 1'b0, 1'b0, '0);
    cycle(3'b000, 1'b0, 1'b0, '0);
    cycle(3'b000, 1'b0, 1'b0, '0);

`ifdef GTECH_AOI3_ARB_LOCK_EN
    mid_reset();
    for (int i = 0; i < 10; i++) cycle(3'b011, 1'b1, 1'b0, '0);
    cycle(3'b011, 1'b0, 1'b0, '0);
    cycle(3'b011, 1'b0, 1'b0, '0);
    cycle(3'b000, 1'b0, 1'b0, '0);
`endif

    // Randomized phase: requests flip occasionally so grants are held for
    // a while, with a clear in the middle.
    r = 3'b000;
    l = 1'b0;
    for (int i = 0; i < 500; i++) begin
      for (int b = 0; b < 3; b++)
        if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
`ifdef GTECH_AOI3_ARB_LOCK_EN
      if ($urandom_range(0, 7) == 0) l = ~l;
`endif
      if (i == 250) mid_reset();
      cycle(r, l, 1'b0, '0);
    end

    @(posedge clk);
    #2;
    check("sb_drained", 32'(sb.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
